// File: rtl/pwm_bank.sv
// pwm_bank: CHANNELS PWM outputs sharing one prescaler and period counter, with shadowed TOP/COMPARE.
// Build option PWM_CENTER_ALIGN_EN adds centre-aligned (up/down) counting selected by CONFIG[1].
module pwm_bank #(
    parameter int ID          = 1,
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int CLOCK_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                peripheralEnable,
    input  logic                peripheralBus_we,
    input  logic                peripheralBus_oe,
    output logic                peripheralBus_busy,
    input  logic [15:0]         peripheralBus_address,
    input  logic [3:0]          peripheralBus_byteSelect,
    input  logic [31:0]         peripheralBus_dataWrite,
    output logic [31:0]         peripheralBus_dataRead,
    output logic                requestOutput,
    output logic [CHANNELS-1:0] pwm_en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                pwm_irq
);

    localparam logic [7:0] OFF_CONFIG   = 8'h00;
    localparam logic [7:0] OFF_PRESCALE = 8'h04;
    localparam logic [7:0] OFF_TOP      = 8'h08;
    localparam logic [7:0] OFF_STATUS   = 8'h0C;
    localparam logic [7:0] OFF_COUNTER  = 8'h10;

    localparam logic [31:0] CH_MASK = (32'd1 << CHANNELS) - 32'd1;
`ifdef PWM_CENTER_ALIGN_EN
    localparam logic [31:0] MODE_MASK = 32'h0000_0007;
`else
    localparam logic [31:0] MODE_MASK = 32'h0000_0005;
`endif
    localparam logic [31:0] CFG_MASK = MODE_MASK | (CH_MASK << 8) | (CH_MASK << 16);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    logic [31:0]                    cfg_q, cfg_d;
    logic [CLOCK_WIDTH-1:0]         prescale_q, prescale_d;
    logic [CLOCK_WIDTH-1:0]         presc_cnt_q, presc_cnt_d;
    logic [WIDTH-1:0]               top_stg_q, top_stg_d;
    logic [WIDTH-1:0]               top_act_q, top_act_d;
    logic [WIDTH-1:0]               counter_q, counter_d;
    logic [CHANNELS-1:0][WIDTH-1:0] cmp_stg_q, cmp_stg_d;
    logic [CHANNELS-1:0][WIDTH-1:0] cmp_act_q, cmp_act_d;
    logic                           wrap_q, wrap_d;
    logic [CHANNELS-1:0]            pwm_out_q, pwm_out_d;
`ifdef PWM_CENTER_ALIGN_EN
    logic                           dir_down_q, dir_down_d;
    logic                           centre;
`endif

    logic                enable;
    logic                irq_en;
    logic [CHANNELS-1:0] chen;
    logic [CHANNELS-1:0] pol;

    assign enable = cfg_q[0];
    assign irq_en = cfg_q[2];
    assign chen   = cfg_q[8 +: CHANNELS];
    assign pol    = cfg_q[16 +: CHANNELS];
`ifdef PWM_CENTER_ALIGN_EN
    assign centre = cfg_q[1];
`endif

    // Bus decode
    logic [7:0]          offset;
    logic                id_match;
    logic                sel_cfg, sel_presc, sel_top, sel_status, sel_counter;
    logic [CHANNELS-1:0] sel_cmp;
    logic                map_hit, hit, wr, w1c;

    always_comb begin
        offset      = peripheralBus_address[7:0];
        id_match    = (peripheralBus_address[15:8] == 8'(ID));
        sel_cfg     = (offset == OFF_CONFIG);
        sel_presc   = (offset == OFF_PRESCALE);
        sel_top     = (offset == OFF_TOP);
        sel_status  = (offset == OFF_STATUS);
        sel_counter = (offset == OFF_COUNTER);
        sel_cmp     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_cmp[i] = (offset == 8'(32 + 4 * i));
        end
        map_hit = sel_cfg | sel_presc | sel_top | sel_status | sel_counter | (|sel_cmp);
        hit     = peripheralEnable & id_match & map_hit;
        wr      = hit & peripheralBus_we;
        w1c     = wr & sel_status & peripheralBus_byteSelect[0] & peripheralBus_dataWrite[0];
    end

    // Read path is purely combinational; held quiet while reset is asserted.
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (sel_cfg)     rdata = cfg_q;
        if (sel_presc)   rdata = 32'(prescale_q);
        if (sel_top)     rdata = 32'(top_stg_q);
        if (sel_status)  rdata = {31'd0, wrap_q};
        if (sel_counter) rdata = 32'(counter_q);
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_cmp[i]) rdata = 32'(cmp_stg_q[i]);
        end
    end

    assign requestOutput          = hit & peripheralBus_oe & rst;
    assign peripheralBus_dataRead = requestOutput ? rdata : '1;
    assign peripheralBus_busy     = 1'b0;

    always_comb begin
        cfg_d      = cfg_q;
        prescale_d = prescale_q;
        top_stg_d  = top_stg_q;
        cmp_stg_d  = cmp_stg_q;
        if (wr && sel_cfg) begin
            cfg_d = merge_bytes(cfg_q, peripheralBus_dataWrite, peripheralBus_byteSelect) & CFG_MASK;
        end
        if (wr && sel_presc) begin
            prescale_d = CLOCK_WIDTH'(merge_bytes(32'(prescale_q), peripheralBus_dataWrite,
                                                  peripheralBus_byteSelect));
        end
        if (wr && sel_top) begin
            top_stg_d = WIDTH'(merge_bytes(32'(top_stg_q), peripheralBus_dataWrite,
                                           peripheralBus_byteSelect));
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr && sel_cmp[i]) begin
                cmp_stg_d[i] = WIDTH'(merge_bytes(32'(cmp_stg_q[i]), peripheralBus_dataWrite,
                                                  peripheralBus_byteSelect));
            end
        end
    end

    // Prescaler and period counter
    logic tick;
    logic boundary;

    always_comb begin
        presc_cnt_d = presc_cnt_q;
        counter_d   = counter_q;
        tick        = 1'b0;
        boundary    = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_down_d  = dir_down_q;
`endif
        if (!enable) begin
            presc_cnt_d = '0;
            counter_d   = '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_d  = 1'b0;
`endif
        end else begin
            // Equality compare: a PRESCALE lowered below the running count wraps through 2^CLOCK_WIDTH.
            if (presc_cnt_q == prescale_q) begin
                tick        = 1'b1;
                presc_cnt_d = '0;
            end else begin
                presc_cnt_d = presc_cnt_q + CLOCK_WIDTH'(1);
            end
            if (tick) begin
                if (top_act_q == '0) begin
                    counter_d = '0;
                    boundary  = 1'b1;
                end
`ifdef PWM_CENTER_ALIGN_EN
                else if (centre) begin
                    if (dir_down_q || (counter_q == top_act_q)) begin
                        counter_d  = counter_q - WIDTH'(1);
                        dir_down_d = 1'b1;
                    end else begin
                        counter_d = counter_q + WIDTH'(1);
                    end
                    if (dir_down_d && (counter_d == '0)) begin
                        boundary   = 1'b1;
                        dir_down_d = 1'b0;
                    end
                end
`endif
                else if (counter_q == top_act_q) begin
                    counter_d = '0;
                    boundary  = 1'b1;
                end else begin
                    counter_d = counter_q + WIDTH'(1);
                end
            end
`ifdef PWM_CENTER_ALIGN_EN
            if (!centre || (top_act_q == '0)) begin
                dir_down_d = 1'b0;
            end
`endif
        end
    end

    // Active copies follow staging while disabled, so enabling starts from the staged values.
    always_comb begin
        top_act_d = top_act_q;
        cmp_act_d = cmp_act_q;
        if (!enable || boundary) begin
            top_act_d = top_stg_q;
            cmp_act_d = cmp_stg_q;
        end
        wrap_d = wrap_q;
        if (w1c) begin
            wrap_d = 1'b0;
        end
        if (boundary) begin
            wrap_d = 1'b1;
        end
        pwm_out_d = pwm_out_q;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_out_d[i] = pwm_en[i] ? ((counter_q < cmp_act_q[i]) ^ pol[i]) : pol[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_q       <= '0;
            prescale_q  <= '0;
            presc_cnt_q <= '0;
            top_stg_q   <= '0;
            top_act_q   <= '0;
            counter_q   <= '0;
            cmp_stg_q   <= '0;
            cmp_act_q   <= '0;
            wrap_q      <= 1'b0;
            pwm_out_q   <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_q  <= 1'b0;
`endif
        end else begin
            cfg_q       <= cfg_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            top_stg_q   <= top_stg_d;
            top_act_q   <= top_act_d;
            counter_q   <= counter_d;
            cmp_stg_q   <= cmp_stg_d;
            cmp_act_q   <= cmp_act_d;
            wrap_q      <= wrap_d;
            pwm_out_q   <= pwm_out_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_down_q  <= dir_down_d;
`endif
        end
    end

    assign pwm_en  = chen & {CHANNELS{enable}};
    assign pwm_out = pwm_out_q;
    assign pwm_irq = wrap_q & irq_en;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: constant table, directed sequences and randomized cases
// checked against an arithmetic model of the counter, shadowed compare and wrap flag.
module tb_pwm_bank;

    localparam int CH = 4;

    localparam logic [7:0] A_CFG  = 8'h00;
    localparam logic [7:0] A_PRE  = 8'h04;
    localparam logic [7:0] A_TOP  = 8'h08;
    localparam logic [7:0] A_STAT = 8'h0C;
    localparam logic [7:0] A_CNT  = 8'h10;
    localparam logic [7:0] A_CMP0 = 8'h20;
    localparam int NEVER = 1 << 30;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pen = 1'b1;
    logic          we = 1'b0;
    logic          oe = 1'b0;
    logic [15:0]   addr = '0;
    logic [3:0]    be = '0;
    logic [31:0]   wdata = '0;
    logic          busy;
    logic [31:0]   rdata;
    logic          req;
    logic [CH-1:0] pwm_en;
    logic [CH-1:0] pwm_out;
    logic          irq;

    int tests = 0;
    int fails = 0;
    int cmp_cfg[CH];

    always #5 clk = ~clk;

    pwm_bank #(.ID(1), .CHANNELS(CH), .WIDTH(16), .CLOCK_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .peripheralEnable(pen),
        .peripheralBus_we(we), .peripheralBus_oe(oe), .peripheralBus_busy(busy),
        .peripheralBus_address(addr), .peripheralBus_byteSelect(be),
        .peripheralBus_dataWrite(wdata), .peripheralBus_dataRead(rdata),
        .requestOutput(req), .pwm_en(pwm_en), .pwm_out(pwm_out), .pwm_irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_rd(input logic [7:0] id, input logic [7:0] off,
                          output logic [31:0] d, output logic r);
        addr = {id, off};
        oe = 1'b1;
        #1;
        d = rdata;
        r = req;
        oe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] d);
        logic r;
        bus_rd(8'd1, off, d, r);
    endtask

    // One clock: optional write committed on the posedge, returns 1ns after it.
    task automatic cyc(input bit do_wr, input logic [7:0] off, input logic [31:0] data,
                       input logic [3:0] bsel);
        @(negedge clk);
        if (do_wr) begin
            addr = {8'd1, off};
            wdata = data;
            be = bsel;
            we = 1'b1;
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        be = 4'h0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] data);
        cyc(1'b1, off, data, 4'hF);
    endtask

    // Output sampled n clocks after the enabling edge reflects the counter one clock earlier.
    // The counter is the tick count mod (TOP+1); a compare write at clock w is used from the
    // first period that starts strictly after w.
    function automatic bit exp_raw(int n, int p, int t, int c_old, int c_new, int w);
        int m, k, cnt, per, len, c;
        m = n - 1;
        k = m / (p + 1);
        cnt = k % (t + 1);
        per = k / (t + 1);
        len = (t + 1) * (p + 1);
        c = (per > 0 && w < per * len) ? c_new : c_old;
        return cnt < c;
    endfunction

    task automatic run_case(input int p, input int t, input int c_old, input int c_new,
                            input int w, input int w1c, input logic [CH-1:0] pol,
                            input logic [CH-1:0] chen, input bit irqen, input int nsamp,
                            input string tag);
        int len, last_b;
        logic [31:0] d;
        logic [CH-1:0] eo;
        bit flag, raw;
        len = (t + 1) * (p + 1);
        wr(A_CFG, 32'd0);
        wr(A_STAT, 32'd1);
        wr(A_PRE, 32'(p));
        wr(A_TOP, 32'(t));
        for (int i = 0; i < CH; i++) wr(8'(32 + 4 * i), 32'((i == 0) ? c_old : cmp_cfg[i]));
        wr(A_CFG, (32'(pol) << 16) | (32'(chen) << 8) | (32'(irqen) << 2) | 32'd1);
        for (int n = 1; n <= nsamp; n++) begin
            if (n == w) cyc(1'b1, A_CMP0, 32'(c_new), 4'hF);
            else if (n == w1c) cyc(1'b1, A_STAT, 32'd1, 4'hF);
            else cyc(1'b0, 8'h00, 32'd0, 4'h0);
            for (int i = 0; i < CH; i++) begin
                raw = (i == 0) ? exp_raw(n, p, t, c_old, c_new, w)
                               : exp_raw(n, p, t, cmp_cfg[i], cmp_cfg[i], NEVER);
                eo[i] = chen[i] ? (raw ^ pol[i]) : pol[i];
            end
            check($sformatf("%s out n=%0d", tag, n), 32'(pwm_out), 32'(eo));
            check($sformatf("%s en n=%0d", tag, n), 32'(pwm_en), 32'(chen));
            rd(A_CNT, d);
            check($sformatf("%s counter n=%0d", tag, n), d, 32'((n / (p + 1)) % (t + 1)));
            last_b = (n / len) * len;
            flag = (last_b > 0) && !(w1c <= n && w1c > last_b);
            rd(A_STAT, d);
            check($sformatf("%s wrap n=%0d", tag, n), d, 32'(flag));
            check($sformatf("%s irq n=%0d", tag, n), 32'(irq), 32'(flag & irqen));
        end
    endtask

    typedef struct {
        int   p;
        int   t;
        int   c;
        logic pol;
        logic chen;
        int   exp_high;
        logic exp_en;
        int   exp_len;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] d;
        logic r;
        int high, first;
        int p, t, c_old, c_new, w, w1c, len;
        logic [7:0] offs[9];

        tbl[0] = '{0, 9, 3, 1'b0, 1'b1, 3,  1'b1, 10};
        tbl[1] = '{3, 4, 2, 1'b0, 1'b1, 8,  1'b1, 20};
        tbl[2] = '{3, 4, 0, 1'b0, 1'b1, 0,  1'b1, 20};
        tbl[3] = '{3, 4, 5, 1'b0, 1'b1, 20, 1'b1, 20};
        tbl[4] = '{3, 4, 2, 1'b1, 1'b1, 12, 1'b1, 20};
        tbl[5] = '{3, 4, 2, 1'b1, 1'b0, 20, 1'b0, 20};
        tbl[6] = '{1, 0, 1, 1'b0, 1'b1, 2,  1'b1, 2};
        tbl[7] = '{2, 0, 0, 1'b0, 1'b1, 0,  1'b1, 3};
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h24, 8'h28, 8'h2C};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst pwm_out", 32'(pwm_out), 32'd0);
        check("rst pwm_en", 32'(pwm_en), 32'd0);
        check("rst irq", 32'(irq), 32'd0);
        bus_rd(8'd1, A_CFG, d, r);
        check("rst req", 32'(r), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            bus_rd(8'd1, offs[i], d, r);
            check($sformatf("init reg %0h", offs[i]), d, 32'd0);
            check($sformatf("init req %0h", offs[i]), 32'(r), 32'd1);
        end
        check("busy", 32'(busy), 32'd0);

        // Bus decode and byte lanes
        cyc(1'b1, A_PRE, 32'hAABB_CCDD, 4'b0101);
        rd(A_PRE, d);
        check("prescale bytesel", d, 32'h00BB_00DD);
        wr(A_PRE, 32'd0);
        cyc(1'b1, A_TOP, 32'h0000_1234, 4'b0010);
        rd(A_TOP, d);
        check("top bytesel", d, 32'h0000_1200);
        wr(A_TOP, 32'd0);
        wr(A_CNT, 32'h55);
        rd(A_CNT, d);
        check("counter ro", d, 32'd0);
        bus_rd(8'd1, 8'h14, d, r);
        check("unmapped req", 32'(r), 32'd0);
        check("unmapped data", d, 32'hFFFF_FFFF);
        bus_rd(8'd2, A_CFG, d, r);
        check("wrong id req", 32'(r), 32'd0);
        pen = 1'b0;
        bus_rd(8'd1, A_CFG, d, r);
        check("no select req", 32'(r), 32'd0);
        pen = 1'b1;
        wr(A_CFG, 32'hFFFF_FFFE);
        rd(A_CFG, d);
`ifdef PWM_CENTER_ALIGN_EN
        check("config mask", d, 32'h000F_0F06);
`else
        check("config mask", d, 32'h000F_0F04);
`endif
        wr(A_CFG, 32'd0);

        // Constant table: duty and period per configuration
        for (int v = 0; v < 8; v++) begin
            wr(A_CFG, 32'd0);
            wr(A_STAT, 32'd1);
            wr(A_PRE, 32'(tbl[v].p));
            wr(A_TOP, 32'(tbl[v].t));
            wr(A_CMP0, 32'(tbl[v].c));
            wr(A_CFG, {15'd0, tbl[v].pol, 7'd0, tbl[v].chen, 7'd0, 1'b1});
            high = 0;
            first = 0;
            for (int n = 1; n <= tbl[v].exp_len + 1; n++) begin
                cyc(1'b0, 8'h00, 32'd0, 4'h0);
                if (n <= tbl[v].exp_len && pwm_out[0]) high++;
                if (n == 1) check($sformatf("tbl%0d en", v), 32'(pwm_en[0]), 32'(tbl[v].exp_en));
                rd(A_STAT, d);
                if (first == 0 && d[0]) first = n;
            end
            check($sformatf("tbl%0d high", v), 32'(high), 32'(tbl[v].exp_high));
            check($sformatf("tbl%0d period", v), 32'(first), 32'(tbl[v].exp_len));
        end

        // Shadowed compare, coincident writes, W1C
        cmp_cfg = '{0, 1, 4, 12};
        run_case(0, 9, 3, 7, 4, NEVER, 4'h0, 4'hF, 1'b0, 35, "shadow mid");
        run_case(0, 9, 3, 7, 10, NEVER, 4'h2, 4'hF, 1'b0, 35, "shadow wrap edge");
        run_case(0, 3, 2, 2, NEVER, 6, 4'h0, 4'h1, 1'b1, 12, "w1c");
        run_case(0, 3, 2, 2, NEVER, 8, 4'h0, 4'h1, 1'b1, 12, "w1c on wrap");

`ifdef PWM_CENTER_ALIGN_EN
        begin
            int k, pos;
            bit flag;
            wr(A_CFG, 32'd0);
            wr(A_STAT, 32'd1);
            wr(A_PRE, 32'd1);
            wr(A_TOP, 32'd4);
            wr(A_CMP0, 32'd2);
            wr(A_CFG, 32'h0000_0103);
            for (int n = 1; n <= 40; n++) begin
                cyc(1'b0, 8'h00, 32'd0, 4'h0);
                k = n / 2;
                pos = k % 8;
                rd(A_CNT, d);
                check($sformatf("centre counter n=%0d", n), d, 32'((pos <= 4) ? pos : 8 - pos));
                k = (n - 1) / 2;
                pos = k % 8;
                check($sformatf("centre out n=%0d", n), 32'(pwm_out[0]),
                      32'(((pos <= 4) ? pos : 8 - pos) < 2));
                flag = (n >= 16);
                rd(A_STAT, d);
                check($sformatf("centre wrap n=%0d", n), d, 32'(flag));
            end
        end
`endif

        // Randomized cases against the model
        for (int it = 0; it < 8; it++) begin
            p = int'($urandom_range(0, 3));
            t = int'($urandom_range(0, 10));
            len = (t + 1) * (p + 1);
            c_old = int'($urandom_range(0, t + 2));
            c_new = int'($urandom_range(0, t + 2));
            for (int i = 0; i < CH; i++) cmp_cfg[i] = int'($urandom_range(0, t + 2));
            w = int'($urandom_range(1, 3 * len));
            w1c = int'($urandom_range(1, 3 * len));
            if (w1c == w) w1c = w + 1;
            run_case(p, t, c_old, c_new, w, w1c, 4'($urandom), 4'($urandom), 1'($urandom),
                     3 * len + 2, $sformatf("rand%0d", it));
        end

        // Asynchronous reset mid-period
        wr(A_CFG, 32'd0);
        wr(A_STAT, 32'd1);
        wr(A_PRE, 32'd0);
        wr(A_TOP, 32'd1);
        wr(A_CFG, 32'h000F_0005);
        repeat (4) cyc(1'b0, 8'h00, 32'd0, 4'h0);
        check("pre-reset out", 32'(pwm_out), 32'hF);
        check("pre-reset irq", 32'(irq), 32'd1);
        @(negedge clk);
        #2;
        addr = {8'd1, A_CFG};
        oe = 1'b1;
        rst = 1'b0;
        #1;
        check("async rst out", 32'(pwm_out), 32'd0);
        check("async rst en", 32'(pwm_en), 32'd0);
        check("async rst irq", 32'(irq), 32'd0);
        check("async rst req", 32'(req), 32'd0);
        oe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            rd(offs[i], d);
            check($sformatf("post-rst reg %0h", offs[i]), d, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
